// File: rtl/r_type_issue.sv
// Issue/writeback front end for an external combinational R-type ALU.
// Holds x0..x31, issues one instruction at a time and writes the ALU result back to rd.
module r_type_issue #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_in,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic [31:0] retired,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    state_t      state;
    state_t      state_next;
    logic [31:0] regs [0:31];
    logic [4:0]  rd_q;
    logic [3:0]  lat_cnt;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        accept;
    logic        is_rtype;
    logic        wb_fire;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign opcode      = instr_in[6:0];
    assign rd          = instr_in[11:7];
    assign rs1         = instr_in[19:15];
    assign rs2         = instr_in[24:20];
    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid & instr_ready;
    assign is_rtype    = (opcode == OPC_RTYPE);
    assign wb_fire     = (state == EXEC) && (lat_cnt == 4'd0);

    // x0 is never written, but the explicit mux keeps the zero read obvious
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_rtype) state_next = EXEC;
            EXEC: if (lat_cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_instr <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            rd_q      <= '0;
            lat_cnt   <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            wb_valid <= wb_fire;
            illegal  <= accept & ~is_rtype;
            if (accept && is_rtype) begin
                alu_instr <= instr_in;
                alu_in1   <= rs1_val;
                alu_in2   <= rs2_val;
                rd_q      <= rd;
                lat_cnt   <= 4'(ALU_LAT - 1);
            end
            if (state == EXEC && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (wb_fire) begin
                wb_rd   <= rd_q;
                wb_data <= alu_out;
                retired <= retired + 32'd1;
            end
        end
    end

    // Preload only happens in IDLE and writeback only in EXEC, so they never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == IDLE && ld_en && ld_addr != 5'd0) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_fire && rd_q != 5'd0) begin
                regs[rd_q] <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_r_type_issue.sv
// Self-checking bench for r_type_issue: one instance at ALU_LAT=1 and one at ALU_LAT=3.
module tb_r_type_issue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        illegal_exp;
        logic [31:0] data_exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [4:0]  dbg_addr;

    logic        ready_a, ready_b, wbv_a, wbv_b, ill_a, ill_b;
    logic [31:0] ai_a, ai_b, in1_a, in1_b, in2_a, in2_b, aout_a, aout_b;
    logic [4:0]  wbrd_a, wbrd_b;
    logic [31:0] wbd_a, wbd_b, ret_a, ret_b, dbg_a, dbg_b;

    logic        m_ready, m_wb_valid, m_illegal;
    logic [31:0] m_alu_instr, m_in1, m_in2, m_wb_data, m_retired, m_dbg;
    logic [4:0]  m_wb_rd;

    int          checks;
    int          failures;
    wb_t         sb_q[$];
    logic [31:0] model_regs [0:31];
    logic [31:0] model_ret [0:1];
    vec_t        vecs [0:7];

    function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [9:0] fn;
        fn = {ins[31:25], ins[14:12]};
        case (fn)
            {7'h00, 3'h0}: return a + b;
            {7'h20, 3'h0}: return a - b;
            {7'h00, 3'h4}: return a ^ b;
            {7'h00, 3'h6}: return a | b;
            {7'h00, 3'h7}: return a & b;
            default:       return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                       input logic [2:0] f3, input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    assign aout_a = alu(ai_a, in1_a, in2_a);
    assign aout_b = alu(ai_b, in1_b, in2_b);

    r_type_issue #(.ALU_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(instr_valid & ~sel), .instr_ready(ready_a),
        .instr_in(instr_in), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_instr(ai_a), .alu_in1(in1_a), .alu_in2(in2_a), .alu_out(aout_a),
        .wb_valid(wbv_a), .wb_rd(wbrd_a), .wb_data(wbd_a), .illegal(ill_a),
        .retired(ret_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
    );

    r_type_issue #(.ALU_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .instr_valid(instr_valid & sel), .instr_ready(ready_b),
        .instr_in(instr_in), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_instr(ai_b), .alu_in1(in1_b), .alu_in2(in2_b), .alu_out(aout_b),
        .wb_valid(wbv_b), .wb_rd(wbrd_b), .wb_data(wbd_b), .illegal(ill_b),
        .retired(ret_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    assign m_ready     = sel ? ready_b : ready_a;
    assign m_wb_valid  = sel ? wbv_b   : wbv_a;
    assign m_illegal   = sel ? ill_b   : ill_a;
    assign m_alu_instr = sel ? ai_b    : ai_a;
    assign m_in1       = sel ? in1_b   : in1_a;
    assign m_in2       = sel ? in2_b   : in2_a;
    assign m_wb_rd     = sel ? wbrd_b  : wbrd_a;
    assign m_wb_data   = sel ? wbd_b   : wbd_a;
    assign m_retired   = sel ? ret_b   : ret_a;
    assign m_dbg       = sel ? dbg_b   : dbg_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard: every writeback of the selected instance must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && m_wb_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_wb: got rd=%0d data=0x%08h expected none", m_wb_rd, m_wb_data);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                checkOutput("wb_rd", 32'(m_wb_rd), 32'(e.rd));
                checkOutput("wb_data", m_wb_data, e.data);
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (a != 5'd0) model_regs[a] = d;
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = m_dbg;
    endtask

    task automatic pushExpect(input logic [31:0] ins, input logic [31:0] data);
        wb_t e;
        e.rd = ins[11:7];
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Drives instr_valid until the instance accepts; returns one step after the accept edge
    task automatic applyStimulus(input logic [31:0] ins);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr_in = ins;
        while (!m_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_ready) checkOutput("accept_timeout", 32'(m_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic waitWb(input string name);
        int n;
        n = 0;
        while (!m_wb_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_wb_valid) checkOutput(name, 32'(m_wb_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] rd_val;
        logic [31:0] last_instr;
        logic [31:0] ins;
        logic [4:0]  a1, a2, d;
        int          low;
        int          held_bad;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        sel = 1'b0;
        instr_valid = 1'b0;
        instr_in = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        dbg_addr = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_ret[0] = '0;
        model_ret[1] = '0;

        vecs[0] = '{instr: 32'h002081B3, v1: 32'd5, v2: 32'd7, illegal_exp: 1'b0, data_exp: 32'd12};
        vecs[1] = '{instr: 32'h40110233, v1: 32'd7, v2: 32'd5, illegal_exp: 1'b0, data_exp: 32'd2};
        vecs[2] = '{instr: mk(7'h00, 5'd11, 5'd10, 3'h4, 5'd12), v1: 32'hFFFF0000, v2: 32'h0F0F0F0F,
                    illegal_exp: 1'b0, data_exp: 32'hF0F00F0F};
        vecs[3] = '{instr: mk(7'h00, 5'd14, 5'd13, 3'h0, 5'd15), v1: 32'hFFFFFFFF, v2: 32'd1,
                    illegal_exp: 1'b0, data_exp: 32'd0};
        vecs[4] = '{instr: mk(7'h20, 5'd17, 5'd16, 3'h0, 5'd18), v1: 32'd3, v2: 32'd10,
                    illegal_exp: 1'b0, data_exp: 32'hFFFFFFF9};
        vecs[5] = '{instr: 32'h00000013, v1: 32'd0, v2: 32'd0, illegal_exp: 1'b1, data_exp: 32'd0};
        vecs[6] = '{instr: 32'h00208033, v1: 32'd5, v2: 32'd7, illegal_exp: 1'b0, data_exp: 32'd12};
        vecs[7] = '{instr: mk(7'h00, 5'd21, 5'd20, 3'h7, 5'd22), v1: 32'h0000F0F0, v2: 32'h00000FF0,
                    illegal_exp: 1'b0, data_exp: 32'h000000F0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(m_ready), 32'd1);
        checkOutput("rst_alu_instr", m_alu_instr, 32'd0);
        checkOutput("rst_alu_in1", m_in1, 32'd0);
        checkOutput("rst_wb_valid", 32'(m_wb_valid), 32'd0);
        checkOutput("rst_illegal", 32'(m_illegal), 32'd0);
        checkOutput("rst_retired", m_retired, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        last_instr = 32'd0;
        for (int i = 0; i < 8; i++) begin
            ins = vecs[i].instr;
            a1 = ins[19:15];
            a2 = ins[24:20];
            d  = ins[11:7];
            preload(a1, vecs[i].v1);
            preload(a2, vecs[i].v2);
            if (vecs[i].illegal_exp) begin
                applyStimulus(ins);
                checkOutput("illegal_pulse", 32'(m_illegal), 32'd1);
                checkOutput("illegal_ready", 32'(m_ready), 32'd1);
                checkOutput("illegal_alu_held", m_alu_instr, last_instr);
                @(posedge clk); #1;
                checkOutput("illegal_clear", 32'(m_illegal), 32'd0);
                checkOutput("illegal_no_wb", 32'(m_wb_valid), 32'd0);
                checkOutput("illegal_retired", m_retired, model_ret[0]);
            end else begin
                pushExpect(ins, vecs[i].data_exp);
                applyStimulus(ins);
                checkOutput("alu_instr", m_alu_instr, ins);
                checkOutput("alu_in1", m_in1, vecs[i].v1);
                checkOutput("alu_in2", m_in2, vecs[i].v2);
                checkOutput("exec_ready_low", 32'(m_ready), 32'd0);
                waitWb("wb_timeout");
                checkOutput("wb_ready_high", 32'(m_ready), 32'd1);
                if (d != 5'd0) model_regs[d] = vecs[i].data_exp;
                model_ret[0] = model_ret[0] + 32'd1;
                last_instr = ins;
                readReg(d, rd_val);
                checkOutput("reg_rd", rd_val, model_regs[d]);
                checkOutput("retired", m_retired, model_ret[0]);
                @(posedge clk); #1;
            end
        end

        // ALU_LAT=3: busy window, ignored preload in EXEC, held second request, no forwarding needed
        sel = 1'b1;
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        pushExpect(32'h40110233, 32'd2);
        ins = mk(7'h00, 5'd4, 5'd4, 3'h0, 5'd6);
        pushExpect(ins, 32'd4);
        applyStimulus(32'h40110233);
        instr_valid = 1'b1;
        instr_in = ins;
        low = 0;
        held_bad = 0;
        while (!m_ready && low < 20) begin
            if (m_alu_instr !== 32'h40110233) held_bad++;
            ld_en = (low == 0);
            ld_addr = 5'd9;
            ld_data = 32'h55;
            low++;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
        checkOutput("lat3_ready_low_cycles", 32'(low), 32'd3);
        checkOutput("lat3_alu_held", 32'(held_bad), 32'd0);
        checkOutput("lat3_wb_with_ready", 32'(m_wb_valid), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checkOutput("lat3_second_instr", m_alu_instr, ins);
        checkOutput("lat3_second_in1", m_in1, 32'd2);
        waitWb("lat3_wb_timeout");
        readReg(5'd4, rd_val);
        checkOutput("lat3_x4", rd_val, 32'd2);
        readReg(5'd6, rd_val);
        checkOutput("lat3_x6", rd_val, 32'd4);
        readReg(5'd9, rd_val);
        checkOutput("exec_preload_ignored", rd_val, 32'd0);
        checkOutput("lat3_retired", m_retired, 32'd2);
        @(posedge clk); #1;

        // Reset while in EXEC aborts the writeback
        applyStimulus(mk(7'h00, 5'd2, 5'd1, 3'h0, 5'd8));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(m_ready), 32'd1);
        checkOutput("midrst_alu_instr", m_alu_instr, 32'd0);
        checkOutput("midrst_alu_in1", m_in1, 32'd0);
        checkOutput("midrst_alu_in2", m_in2, 32'd0);
        checkOutput("midrst_retired", m_retired, 32'd0);
        checkOutput("midrst_wb_rd", 32'(m_wb_rd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        readReg(5'd8, rd_val);
        checkOutput("midrst_x8_unwritten", rd_val, 32'd0);
        checkOutput("midrst_ready_after", 32'(m_ready), 32'd1);
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_ret[0] = '0;
        model_ret[1] = '0;

        // Preload and accept on the same edge: operands see the pre-edge value
        sel = 1'b0;
        preload(5'd3, 32'd1);
        ins = mk(7'h00, 5'd3, 5'd3, 3'h0, 5'd5);
        pushExpect(ins, 32'd2);
        ld_en = 1'b1;
        ld_addr = 5'd3;
        ld_data = 32'd9;
        instr_valid = 1'b1;
        instr_in = ins;
        @(posedge clk); #1;
        ld_en = 1'b0;
        instr_valid = 1'b0;
        checkOutput("same_edge_in1", m_in1, 32'd1);
        checkOutput("same_edge_in2", m_in2, 32'd1);
        waitWb("same_edge_wb_timeout");
        readReg(5'd3, rd_val);
        checkOutput("same_edge_x3", rd_val, 32'd9);
        readReg(5'd5, rd_val);
        checkOutput("same_edge_x5", rd_val, 32'd2);
        readReg(5'd0, rd_val);
        checkOutput("x0_reads_zero", rd_val, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
